// File: rtl/bcd_pkg.sv
// Shared BCD definitions: converter FSM states, digit constants and digit check.
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int         BCD_DIGIT_W   = 4;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  function automatic logic digit_valid(input logic [BCD_DIGIT_W-1:0] d);
    return d <= BCD_MAX_DIGIT;
  endfunction
endpackage

// File: rtl/bcd_digit_corr.sv
// One BCD digit correction for reverse double-dabble: subtract 3 when the digit is >= 8.
module bcd_digit_corr
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);
  assign o_digit = i_digit[BCD_DIGIT_W-1] ? i_digit - 4'd3 : i_digit;
endmodule

// File: rtl/bcd_to_bin.sv
// Iterative BCD-to-binary converter, one shift-and-correct step per clock.
// Define BCD_CHECK_EN to reject invalid digits at start (err=1, no conversion).
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                          clock,
  input  logic                          clear_n,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                          busy,
  output logic                          done,
  output logic [BIN_W-1:0]              bin_out,
  output logic                          err
);
  localparam int BCD_W  = BCD_DIGIT_W * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  state_t             r_state, w_next;
  logic [WORK_W-1:0]  r_work;
  logic [WORK_W-1:0]  w_shift, w_step;
  logic [CNT_W-1:0]   r_cnt;
  logic [BIN_W-1:0]   r_bin;
  logic               r_err;
  logic               w_last;
  logic               w_bad;

  // Working register is {bcd_field, bin_field}; bcd LSB falls into bin MSB.
  assign w_shift = r_work >> 1;
  assign w_step[BIN_W-1:0] = w_shift[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_digit_corr u_corr (
      .i_digit (w_shift[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_step [BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign w_last = (r_cnt == CNT_W'(BIN_W - 1));

`ifdef BCD_CHECK_EN
  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (!digit_valid(bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W])) w_bad = 1'b1;
  end
`else
  assign w_bad = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!clear_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = w_bad ? DONE : RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_bin  <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_work <= {bcd_in, {BIN_W{1'b0}}};
          r_cnt  <= '0;
          if (w_bad) begin
            r_bin <= '0;
            r_err <= 1'b1;
          end
        end
        RUN: begin
          r_work <= w_step;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            r_bin <= w_step[BIN_W-1:0];
            r_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state == RUN);
  assign done    = (r_state == DONE);
  assign bin_out = r_bin;
  assign err     = r_err;
endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: decimal-value model plus directed vectors.
module tb_bcd_to_bin;
  import bcd_pkg::*;

  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bcd_in = '0;
  logic        busy, done, err;
  logic [13:0] bin_out;

  logic        start_b = 1'b0;
  logic [3:0]  bcd_b = '0;
  logic        busy_b, done_b, err_b;
  logic [3:0]  bin_b;

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;

  always #5 clock = ~clock;

  bcd_to_bin #(.DIGITS(4), .BIN_W(14)) dut (
    .clock(clock), .clear_n(clear_n), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .bin_out(bin_out), .err(err));

  bcd_to_bin #(.DIGITS(1), .BIN_W(4)) dut_b (
    .clock(clock), .clear_n(clear_n), .start(start_b), .bcd_in(bcd_b),
    .busy(busy_b), .done(done_b), .bin_out(bin_b), .err(err_b));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dec_val(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic bit has_bad_digit(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[i*4 +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // Model of the 4-digit DUT: m_ph = run edges left, -1 = done cycle, 0 = idle.
  int          m_ph = 0;
  int          m_bin = 0, m_pend = 0;
  bit          m_err = 1'b0, m_known = 1'b1, m_pend_known = 1'b1;

  always @(posedge clock) begin
    if (!clear_n) begin
      m_ph <= 0; m_bin <= 0; m_err <= 1'b0; m_known <= 1'b1;
    end else if (m_ph == -1) begin
      m_ph <= 0;
    end else if (m_ph > 1) begin
      m_ph <= m_ph - 1;
    end else if (m_ph == 1) begin
      m_ph <= -1; m_bin <= m_pend; m_err <= 1'b0; m_known <= m_pend_known;
    end else if (start) begin
      if (has_bad_digit(bcd_in)) begin
`ifdef BCD_CHECK_EN
        m_ph <= -1; m_bin <= 0; m_err <= 1'b1; m_known <= 1'b1;
`else
        m_ph <= 14; m_pend_known <= 1'b0;
`endif
      end else begin
        m_ph <= 14; m_pend <= dec_val(bcd_in); m_pend_known <= 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (mon_en) begin
      chk("busy", int'(busy), int'(m_ph > 0));
      chk("done", int'(done), int'(m_ph == -1));
      chk("err", int'(err), int'(m_err));
      if (m_known) chk("bin_out", int'(bin_out), m_bin);
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!done && n < 40);
  endtask

  task automatic conv(input logic [15:0] v, input int exp_lat, input int exp_bin,
                      input int exp_err, input string name);
    int n;
    @(negedge clock);
    start = 1'b1; bcd_in = v;
    @(negedge clock);
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_latency"}, n, exp_lat);
    chk({name, "_bin"}, int'(bin_out), exp_bin);
    chk({name, "_err"}, int'(err), exp_err);
  endtask

  initial begin
    int n, ndone, last, first;
    repeat (3) @(negedge clock);
    mon_en = 1'b1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_bin", int'(bin_out), 0);
    chk("rst_err", int'(err), 0);
    clear_n = 1'b1;

    conv(16'h0000, 15, 0, 0, "zero");
    conv(16'h9999, 15, 9999, 0, "max");
    conv(16'h1234, 15, 1234, 0, "d1234");
    conv(16'h0500, 15, 500, 0, "d500");

    // Re-start and operand changes while running are ignored.
    @(negedge clock); start = 1'b1; bcd_in = 16'h0555;
    @(negedge clock); start = 1'b0;
    repeat (4) @(negedge clock);
    start = 1'b1; bcd_in = 16'h9999;
    @(negedge clock); start = 1'b0; bcd_in = 16'h1111;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done) begin
        ndone++;
        chk("ignore_bin", int'(bin_out), 555);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk("ignore_ndone", ndone, 1);

    // Reset in the middle of a conversion.
    @(negedge clock); start = 1'b1; bcd_in = 16'h0777;
    @(negedge clock); start = 1'b0;
    repeat (6) @(negedge clock);
    clear_n = 1'b0;
    @(negedge clock);
    clear_n = 1'b1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_bin", int'(bin_out), 0);
    chk("abort_err", int'(err), 0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (done) ndone++;
    end
    chk("abort_ndone", ndone, 0);
    conv(16'h0042, 15, 42, 0, "after_abort");

`ifdef BCD_CHECK_EN
    conv(16'h12A4, 1, 0, 1, "invalid");
`else
    @(negedge clock); start = 1'b1; bcd_in = 16'h12A4;
    @(negedge clock); start = 1'b0;
    wait_done(n);
    chk("invalid_latency", n + 1, 15);
    chk("invalid_err", int'(err), 0);
`endif
    conv(16'h0005, 15, 5, 0, "after_invalid");

    // Start held high: back-to-back conversions every 16 cycles.
    @(negedge clock); start = 1'b1; bcd_in = 16'h0010;
    ndone = 0; last = 0; first = 0;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clock);
      if (done) begin
        ndone++;
        chk("held_bin", int'(bin_out), 10);
        if (ndone == 1) first = i;
        else chk("held_interval", i - last, 16);
        last = i;
      end
    end
    chk("held_first", first, 15);
    chk("held_ndone", ndone, 4);
    start = 1'b0;
    repeat (20) @(negedge clock);

    // Single-digit instance sweep.
    for (int v = 0; v <= 9; v++) begin
      @(negedge clock); start_b = 1'b1; bcd_b = 4'(v);
      @(negedge clock); start_b = 1'b0;
      n = 1;
      while (!done_b && n < 20) begin
        @(negedge clock);
        n++;
      end
      chk("d1_latency", n, 5);
      chk("d1_bin", int'(bin_b), v);
      chk("d1_err", int'(err_b), 0);
    end

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
